// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: buffers commands in a FIFO and issues one one-hot
// bus source select plus one-hot destination load per transfer cycle.
module bus_xfer_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [4:0]               cmd_src,
  input  logic [4:0]               cmd_dst,
  input  logic                     cmd_wait,
  input  logic                     alu_done,
  output logic [23:0]              src_sel,
  output logic [23:0]              dst_load,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic       wt;
    logic [4:0] dst;
    logic [4:0] src;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAlu,
    StDrive
  } state_e;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop, full, empty;
  cmd_t          head;

  state_e        state_q, state_d;
  cmd_t          held_q, held_d;
  logic [23:0]   src_sel_q, src_sel_d;
  logic [23:0]   dst_load_q, dst_load_d;
  logic          err_q, err_d;

  function automatic logic [23:0] onehot(input logic [4:0] code);
    onehot = 24'd1 << code;
  endfunction

  function automatic logic is_legal(input cmd_t c);
    is_legal = (c.src < 5'd24) && (c.dst < 5'd24);
  endfunction

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{wt: cmd_wait, dst: cmd_dst, src: cmd_src};
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    src_sel_d  = '0;
    dst_load_d = '0;
    err_d      = err_q;
    pop        = 1'b0;

    unique case (state_q)
      StWaitAlu: begin
        if (alu_done) begin
          state_d    = StDrive;
          src_sel_d  = onehot(held_q.src);
          dst_load_d = onehot(held_q.dst);
        end
      end
      StIdle, StDrive: begin
        // DRIVE exits with the same pop decision as IDLE for back-to-back issue.
        state_d = StIdle;
        if (!empty) begin
          pop = 1'b1;
          if (!is_legal(head)) begin
            err_d = 1'b1;
          end else if (head.wt) begin
            state_d = StWaitAlu;
            held_d  = head;
          end else begin
            state_d    = StDrive;
            src_sel_d  = onehot(head.src);
            dst_load_d = onehot(head.dst);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= StIdle;
      held_q     <= '0;
      src_sel_q  <= '0;
      dst_load_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      src_sel_q  <= src_sel_d;
      dst_load_q <= dst_load_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = !full;
  assign count     = count_q;
  assign busy      = (state_q != StIdle) || !empty;
  assign src_sel   = src_sel_q;
  assign dst_load  = dst_load_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Self-checking bench for bus_xfer_sequencer: queue-based transfer model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_bus_xfer_sequencer;

  localparam int DEPTH = 4;

  logic        clock;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_dst;
  logic        cmd_wait;
  logic        alu_done;
  logic [23:0] src_sel;
  logic [23:0] dst_load;
  logic        busy;
  logic [2:0]  count;
  logic        err;

  int n_tests;
  int n_fail;

  // Behavioural model: queue of pending commands {wait, dst, src}.
  logic [10:0] mq[$];
  bit          m_waiting;
  logic [10:0] m_held;
  bit          m_drive;
  logic [4:0]  m_src;
  logic [4:0]  m_dst;
  bit          m_err;

  bus_xfer_sequencer #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .clear    (clear),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_src  (cmd_src),
    .cmd_dst  (cmd_dst),
    .cmd_wait (cmd_wait),
    .alu_done (alu_done),
    .src_sel  (src_sel),
    .dst_load (dst_load),
    .busy     (busy),
    .count    (count),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_waiting = 0;
    m_held    = '0;
    m_drive   = 0;
    m_src     = '0;
    m_dst     = '0;
    m_err     = 0;
  endtask

  // Apply one clock edge to the model using the inputs presented before the edge.
  task automatic model_edge();
    bit          acc;
    logic [10:0] c;
    acc     = cmd_valid && (mq.size() < DEPTH);
    m_drive = 0;
    if (m_waiting) begin
      if (alu_done) begin
        m_drive   = 1;
        m_src     = m_held[4:0];
        m_dst     = m_held[9:5];
        m_waiting = 0;
      end
    end else if (mq.size() > 0) begin
      c = mq.pop_front();
      if (c[4:0] >= 5'd24 || c[9:5] >= 5'd24) begin
        m_err = 1;
      end else if (c[10]) begin
        m_waiting = 1;
        m_held    = c;
      end else begin
        m_drive = 1;
        m_src   = c[4:0];
        m_dst   = c[9:5];
      end
    end
    if (acc) mq.push_back({cmd_wait, cmd_dst, cmd_src});
  endtask

  task automatic compare_all();
    logic [31:0] e_src, e_dst;
    e_src = m_drive ? (32'd1 << m_src) : 32'd0;
    e_dst = m_drive ? (32'd1 << m_dst) : 32'd0;
    cmp("src_sel", 32'(src_sel), e_src);
    cmp("dst_load", 32'(dst_load), e_dst);
    cmp("count", 32'(count), 32'(mq.size()));
    cmp("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    cmp("busy", 32'(busy), 32'(m_waiting || m_drive || (mq.size() != 0)));
    cmp("err", 32'(err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_cmd(input bit v, input int s, input int d, input bit w);
    cmd_valid = v;
    cmd_src   = 5'(s);
    cmd_dst   = 5'(d);
    cmd_wait  = w;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    clear     = 1'b0;
    alu_done  = 1'b0;
    set_cmd(0, 0, 0, 0);
    model_reset();

    // Reset values
    #12;
    compare_all();
    cmp("rst_src", 32'(src_sel), 32'h0);
    cmp("rst_ready", 32'(cmd_ready), 32'h1);
    cmp("rst_busy", 32'(busy), 32'h0);
    @(posedge clock);
    #2 clear = 1'b1;

    // Single transfer PC -> MAR
    set_cmd(1, 20, 20, 0);
    step();
    cmp("t1_count", 32'(count), 32'h1);
    set_cmd(0, 0, 0, 0);
    step();
    cmp("t1_src", 32'(src_sel), 32'h100000);
    cmp("t1_dst", 32'(dst_load), 32'h100000);
    step();
    cmp("t1_src_off", 32'(src_sel), 32'h0);
    cmp("t1_busy", 32'(busy), 32'h0);

    // Back-to-back: R3 -> Y, Zlow -> R7
    set_cmd(1, 3, 21, 0);
    step();
    set_cmd(1, 19, 7, 0);
    step();
    cmp("t2_src0", 32'(src_sel), 32'h000008);
    cmp("t2_dst0", 32'(dst_load), 32'h200000);
    set_cmd(0, 0, 0, 0);
    step();
    cmp("t2_src1", 32'(src_sel), 32'h080000);
    cmp("t2_dst1", 32'(dst_load), 32'h000080);
    step();

    // ALU wait: Zlow -> R1
    set_cmd(1, 19, 1, 1);
    step();
    set_cmd(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("t3_hold", 32'(src_sel), 32'h0);
    end
    alu_done = 1'b1;
    step();
    cmp("t3_src", 32'(src_sel), 32'h080000);
    cmp("t3_dst", 32'(dst_load), 32'h000002);
    alu_done = 1'b0;
    step();

    // FIFO full behind a waiting head
    set_cmd(1, 19, 2, 1);
    step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_cmd(1, i, i + 8, 0);
      step();
    end
    cmp("t4_count", 32'(count), 32'h4);
    cmp("t4_ready", 32'(cmd_ready), 32'h0);
    set_cmd(0, 0, 0, 0);
    alu_done = 1'b1;
    step();
    cmp("t4_wsrc", 32'(src_sel), 32'h080000);
    alu_done = 1'b0;
    step();
    cmp("t4_first", 32'(src_sel), 32'h000001);
    cmp("t4_first_dst", 32'(dst_load), 32'h000100);
    for (int i = 0; i < DEPTH; i++) step();
    cmp("t4_idle", 32'(busy), 32'h0);

    // Illegal source code
    set_cmd(1, 27, 0, 0);
    step();
    set_cmd(0, 0, 0, 0);
    step();
    cmp("t5_err", 32'(err), 32'h1);
    cmp("t5_nosel", 32'(src_sel), 32'h0);
    set_cmd(1, 0, 0, 0);
    step();
    set_cmd(0, 0, 0, 0);
    step();
    cmp("t5_legal", 32'(src_sel), 32'h000001);
    cmp("t5_sticky", 32'(err), 32'h1);
    step();

    // Reset while waiting with two entries queued
    set_cmd(1, 19, 4, 1);
    step();
    set_cmd(1, 5, 6, 0);
    step();
    set_cmd(1, 7, 8, 0);
    step();
    set_cmd(0, 0, 0, 0);
    cmp("t6_count", 32'(count), 32'h2);
    clear = 1'b0;
    #1;
    model_reset();
    compare_all();
    cmp("t6_rcount", 32'(count), 32'h0);
    cmp("t6_rerr", 32'(err), 32'h0);
    cmp("t6_rbusy", 32'(busy), 32'h0);
    @(posedge clock);
    #2 clear = 1'b1;
    alu_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("t6_nostale", 32'(src_sel), 32'h0);
    end
    alu_done = 1'b0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      set_cmd(($urandom % 3) != 0, $urandom_range(0, 25), $urandom_range(0, 25),
              ($urandom % 4) == 0);
      alu_done = ($urandom % 3) == 0;
      step();
      if ((i % 400) == 399) begin
        #2 clear = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #2 clear = 1'b1;
      end
    end
    set_cmd(0, 0, 0, 0);
    alu_done = 1'b1;
    for (int i = 0; i < 10; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
